branch_ctrl: RTL and testbench

BRANCH_CTRL -- requirements
Module: branch_ctrl

---
 rtl/branch_ctrl.sv | 144 ++++++++++++++
 tb/tb_branch_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_ctrl.sv
// Branch resolution controller: flag-conditioned branches, call/return stack and
// post-branch pipeline flush sequencing toward the PC unit.
//
// state   | meaning
// --------+----------------------------------------------------------------
// S_IDLE  | accepting requests; not-taken branches stay here
// S_FLUSH | taken branch in flight; flush held, requests ignored
module branch_ctrl #(
    parameter int AW           = 16,
    parameter int FW           = 4,
    parameter int RS_DEPTH     = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid_in,
    output logic          ready_out,
    input  logic [3:0]    branch_type,
    input  logic [AW-1:0] branch_offset,
    input  logic [AW-1:0] pc_current,
    input  logic          flags_we,
    input  logic [FW-1:0] flags_in,
    output logic          branch_taken,
    output logic [AW-1:0] branch_target,
    output logic          flush,
    output logic [FW-1:0] flags_q,
    output logic          rs_empty,
    output logic          rs_full,
    output logic          rs_err
);

    localparam int RSW = $clog2(RS_DEPTH);
    localparam int CW  = RSW + 1;
    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic {S_IDLE, S_FLUSH} state_t;

    state_t          state;
    logic [FCW-1:0]  flush_cnt;
    logic [CW-1:0]   rs_cnt;
    logic [AW-1:0]   rs_mem [RS_DEPTH];

    logic            accept;
    logic            flag_z, flag_s, flag_c;
    logic            take, is_call, is_ret;
    logic [AW-1:0]   rel_target, ret_target, ret_addr;
    logic [RSW-1:0]  top_idx;

    assign ready_out = (state == S_IDLE);
    assign accept    = valid_in & ready_out;

    // A flag write in the accept cycle is visible to that same branch
    assign flag_z = flags_we ? flags_in[0] : flags_q[0];
    assign flag_s = flags_we ? flags_in[1] : flags_q[1];
    assign flag_c = flags_we ? flags_in[2] : flags_q[2];

    assign rs_empty   = (rs_cnt == '0);
    assign rs_full    = (rs_cnt == CW'(RS_DEPTH));
    assign top_idx    = RSW'(rs_cnt - 1'b1);
    assign rel_target = pc_current + branch_offset;
    assign ret_addr   = pc_current + 1'b1;
    assign ret_target = rs_mem[top_idx];

    always_comb begin
        take    = 1'b0;
        is_call = 1'b0;
        is_ret  = 1'b0;
        case (branch_type)
            4'd1: take = 1'b1;
            4'd2: take = flag_z;
            4'd3: take = ~flag_z;
            4'd4: take = ~flag_s;
            4'd5: take = flag_s;
            4'd6: take = flag_c;
            4'd7: take = ~flag_c;
            4'd8: begin
                take    = 1'b1;
                is_call = 1'b1;
            end
            4'd9: begin
                take   = ~rs_empty;
                is_ret = 1'b1;
            end
            default: take = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            flush_cnt     <= '0;
            branch_taken  <= 1'b0;
            branch_target <= '0;
            flush         <= 1'b0;
            flags_q       <= '0;
            rs_cnt        <= '0;
            rs_err        <= 1'b0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                rs_mem[i] <= '0;
            end
        end else begin
            branch_taken <= 1'b0;
            if (flags_we) begin
                flags_q <= flags_in;
            end
            case (state)
                S_IDLE: begin
                    if (accept && take) begin
                        branch_taken  <= 1'b1;
                        branch_target <= is_ret ? ret_target : rel_target;
                        flush         <= 1'b1;
                        flush_cnt     <= FCW'(FLUSH_CYCLES - 1);
                        state         <= S_FLUSH;
                    end
                    if (accept && is_call) begin
                        if (rs_full) begin
                            rs_err <= 1'b1;
                        end else begin
                            rs_mem[rs_cnt[RSW-1:0]] <= ret_addr;
                            rs_cnt <= rs_cnt + 1'b1;
                        end
                    end
                    if (accept && is_ret) begin
                        if (rs_empty) begin
                            rs_err <= 1'b1;
                        end else begin
                            rs_cnt <= rs_cnt - 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    if (flush_cnt == '0) begin
                        flush <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// Randomized bench for branch_ctrl against a queue-based reference model of
// flags, return stack, target register and flush timing.
module tb_branch_ctrl;

    localparam int AW           = 16;
    localparam int FW           = 4;
    localparam int RS_DEPTH     = 4;
    localparam int FLUSH_CYCLES = 2;

    logic          clk;
    logic          rst_n;
    logic          valid_in;
    logic          ready_out;
    logic [3:0]    branch_type;
    logic [AW-1:0] branch_offset;
    logic [AW-1:0] pc_current;
    logic          flags_we;
    logic [FW-1:0] flags_in;
    logic          branch_taken;
    logic [AW-1:0] branch_target;
    logic          flush;
    logic [FW-1:0] flags_q;
    logic          rs_empty;
    logic          rs_full;
    logic          rs_err;

    branch_ctrl #(
        .AW(AW), .FW(FW), .RS_DEPTH(RS_DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_out(ready_out),
        .branch_type(branch_type), .branch_offset(branch_offset),
        .pc_current(pc_current), .flags_we(flags_we), .flags_in(flags_in),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .flush(flush), .flags_q(flags_q), .rs_empty(rs_empty),
        .rs_full(rs_full), .rs_err(rs_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [AW-1:0] m_stack [$];
    logic [FW-1:0] m_flags;
    logic [AW-1:0] m_target;
    logic          m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".target"},   32'(branch_target), 32'(m_target));
        chk({tag, ".flags_q"},  32'(flags_q),       32'(m_flags));
        chk({tag, ".rs_empty"}, 32'(rs_empty),      32'(m_stack.size() == 0));
        chk({tag, ".rs_full"},  32'(rs_full),       32'(m_stack.size() == RS_DEPTH));
        chk({tag, ".rs_err"},   32'(rs_err),        32'(m_err));
    endtask

    task automatic model_reset();
        m_stack.delete();
        m_flags  = '0;
        m_target = '0;
        m_err    = 1'b0;
    endtask

    // One request from IDLE; if taken, walks the whole flush window (optionally
    // holding a would-be-taken BRS request on valid_in) back to IDLE.
    task automatic issue(input logic [3:0] bt, input logic [AW-1:0] pc, input logic [AW-1:0] off,
                         input logic fwe, input logic [FW-1:0] fin, input logic hold);
        logic [FW-1:0] feff;
        logic          take;
        logic [AW-1:0] tgt;
        logic [AW-1:0] link;
        @(negedge clk);
        chk("ready_before_req", 32'(ready_out), 32'd1);
        valid_in      = 1'b1;
        branch_type   = bt;
        pc_current    = pc;
        branch_offset = off;
        flags_we      = fwe;
        flags_in      = fin;
        feff = fwe ? fin : m_flags;
        tgt  = pc + off;
        link = pc + 1'b1;
        take = 1'b0;
        case (bt)
            4'd1: take = 1'b1;
            4'd2: take = feff[0];
            4'd3: take = !feff[0];
            4'd4: take = !feff[1];
            4'd5: take = feff[1];
            4'd6: take = feff[2];
            4'd7: take = !feff[2];
            4'd8: begin
                take = 1'b1;
                if (m_stack.size() == RS_DEPTH) m_err = 1'b1;
                else m_stack.push_back(link);
            end
            4'd9: begin
                if (m_stack.size() == 0) m_err = 1'b1;
                else begin
                    take = 1'b1;
                    tgt  = m_stack.pop_back();
                end
            end
            default: take = 1'b0;
        endcase
        if (fwe) m_flags = fin;
        if (take) m_target = tgt;
        @(posedge clk);
        #1;
        chk("branch_taken", 32'(branch_taken), 32'(take));
        chk("flush_first",  32'(flush),        32'(take));
        chk("ready_after",  32'(ready_out),    32'(!take));
        check_state("accept");
        if (take) begin
            valid_in    = hold;
            branch_type = 4'd5;
            flags_we    = 1'b0;
            for (int k = 1; k < FLUSH_CYCLES; k++) begin
                @(posedge clk);
                #1;
                chk("taken_in_flush", 32'(branch_taken), 32'd0);
                chk("flush_held",     32'(flush),        32'd1);
                chk("ready_in_flush", 32'(ready_out),    32'd0);
                check_state("flush");
            end
            @(posedge clk);
            #1;
            valid_in = 1'b0;
            chk("flush_end",    32'(flush),        32'd0);
            chk("ready_end",    32'(ready_out),    32'd1);
            chk("taken_end",    32'(branch_taken), 32'd0);
            check_state("end");
        end
    endtask

    task automatic go_idle();
        @(negedge clk);
        valid_in = 1'b0;
        flags_we = 1'b0;
    endtask

    initial begin
        logic [3:0] bt;
        rst_n         = 1'b0;
        valid_in      = 1'b0;
        branch_type   = '0;
        branch_offset = '0;
        pc_current    = '0;
        flags_we      = 1'b0;
        flags_in      = '0;
        model_reset();
        #12;
        chk("rst_taken", 32'(branch_taken), 32'd0);
        chk("rst_flush", 32'(flush),        32'd0);
        check_state("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready_out), 32'd1);

        // Same-cycle flag bypass on BRZ
        issue(4'd2, 16'h0010, 16'h0004, 1'b1, 4'b0001, 1'b0);
        chk("brz_target", 32'(branch_target), 32'h0014);
        // Wrapping relative target
        issue(4'd1, 16'hFFFE, 16'h0004, 1'b0, 4'b0000, 1'b0);
        chk("wrap_target", 32'(branch_target), 32'h0002);
        // Call then return
        issue(4'd8, 16'h0100, 16'h0020, 1'b0, 4'b0000, 1'b0);
        chk("call_target", 32'(branch_target), 32'h0120);
        issue(4'd9, 16'h0120, 16'h0000, 1'b0, 4'b0000, 1'b0);
        chk("ret_target", 32'(branch_target), 32'h0101);
        chk("ret_empty",  32'(rs_empty),      32'd1);
        // Overflow: five calls, then five returns
        for (int i = 0; i < 5; i++)
            issue(4'd8, AW'(16'h0200 + 16'h0100 * i), 16'h0008, 1'b0, 4'b0000, 1'b0);
        chk("ovf_full", 32'(rs_full), 32'd1);
        chk("ovf_err",  32'(rs_err),  32'd1);
        for (int i = 0; i < 5; i++)
            issue(4'd9, 16'h0000, 16'h0000, 1'b0, 4'b0000, 1'b0);
        chk("udf_empty", 32'(rs_empty), 32'd1);
        // valid_in held high through the flush window with S=1
        issue(4'd5, 16'h0300, 16'h0010, 1'b1, 4'b0010, 1'b1);
        // Back-to-back not-taken requests
        issue(4'd4, 16'h0400, 16'h0010, 1'b0, 4'b0000, 1'b0);
        issue(4'd0, 16'h0400, 16'h0010, 1'b0, 4'b0000, 1'b0);
        issue(4'd12, 16'h0400, 16'h0010, 1'b0, 4'b0000, 1'b0);
        go_idle();

        repeat (250) begin
            case ($urandom_range(0, 3))
                0:       bt = 4'd8;
                1:       bt = 4'd9;
                default: bt = 4'($urandom_range(0, 15));
            endcase
            issue(bt, AW'($urandom), AW'($urandom), 1'($urandom), FW'($urandom),
                  1'($urandom));
        end
        go_idle();

        // Asynchronous reset in the middle of a flush
        issue(4'd8, 16'h0500, 16'h0010, 1'b0, 4'b0000, 1'b0);
        @(negedge clk);
        valid_in      = 1'b1;
        branch_type   = 4'd1;
        pc_current    = 16'h0040;
        branch_offset = 16'h0010;
        flags_we      = 1'b1;
        flags_in      = 4'b1010;
        @(posedge clk);
        #1;
        chk("pre_rst_taken", 32'(branch_taken), 32'd1);
        chk("pre_rst_flush", 32'(flush),        32'd1);
        valid_in = 1'b0;
        flags_we = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_taken", 32'(branch_taken), 32'd0);
        chk("mid_rst_flush", 32'(flush),        32'd0);
        chk("mid_rst_ready", 32'(ready_out),    32'd1);
        check_state("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", 32'(ready_out), 32'd1);
        chk("post_rst_flush", 32'(flush),     32'd0);
        issue(4'd9, 16'h0000, 16'h0000, 1'b0, 4'b0000, 1'b0);
        issue(4'd1, 16'h1000, 16'hFFF0, 1'b0, 4'b0000, 1'b0);
        go_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
